ball_locator: RTL and testbench

//  Consumes the eroded binary mask (render_o of the erode stage) in raster order, alongside the VTC counters.
//  Per frame: counts mask pixels, accumulates X/Y sums, then divides sequentially during blanking to get the centroid.

---
 rtl/ball_locator.sv | 196 +++++++++++++++++++
 tb/tb_ball_locator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ball_locator.sv
// Ball centroid locator: accumulates eroded-mask pixel count and X/Y sums per frame,
// then divides them serially during blanking. Optional bounding box: BALL_BBOX_EN.
module ball_locator #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned MIN_PIX  = 16
) (
    input  logic        PCLK,
    input  logic        RST_N,
    input  logic [11:0] VtcHCnt,
    input  logic [10:0] VtcVCnt,
    input  logic        mask_i,
    output logic [8:0]  ball_x,
    output logic [7:0]  ball_y,
    output logic        ball_found,
    output logic [16:0] pix_count,
    output logic [8:0]  bbox_xmin,
    output logic [8:0]  bbox_xmax,
    output logic [7:0]  bbox_ymin,
    output logic [7:0]  bbox_ymax,
    output logic        frame_done
);

    localparam int unsigned HW      = 12;
    localparam int unsigned VW      = 11;
    localparam int unsigned CW      = 17;
    localparam int unsigned SW      = 24;
    localparam int unsigned XW      = 9;
    localparam int unsigned YW      = 8;
    localparam int unsigned DCW     = 5;
    localparam int unsigned DIV_CYC = 24;

    localparam logic [HW-1:0]  H_LIM    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]  V_LIM    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [DCW-1:0] STEP_END = DCW'(DIV_CYC - 1);
    localparam logic [DCW-1:0] MSB_IDX  = DCW'(SW - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV_X, S_DIV_Y, S_PUB} state_t;

    state_t         r_state, w_next;
    logic [HW-1:0]  r_h_d;
    logic [VW-1:0]  r_v_d;
    logic [CW-1:0]  r_count;
    logic [SW-1:0]  r_sum_x, r_sum_y;
    logic [DCW-1:0] r_step;
    logic [CW-1:0]  r_rem;
    logic [XW-1:0]  r_qx;
    logic [YW-1:0]  r_qy;

    logic           w_valid, w_start, w_last, w_hit, w_clear, w_step_end;
    logic [SW-1:0]  w_dividend;
    logic [DCW-1:0] w_bitsel;
    logic [CW:0]    w_trial;
    logic           w_qbit;
    logic [CW-1:0]  w_rem_next;

    // Counters delayed one PCLK to line up with the eroded mask
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h_d <= '1;
            r_v_d <= '1;
        end else begin
            r_h_d <= VtcHCnt;
            r_v_d <= VtcVCnt;
        end
    end

    assign w_valid    = (r_h_d < H_LIM) && (r_v_d < V_LIM);
    assign w_start    = (r_h_d == '0) && (r_v_d == '0);
    assign w_last     = (r_h_d == H_LAST) && (r_v_d == V_LAST);
    assign w_hit      = w_valid && mask_i;
    assign w_clear    = ((r_state == S_IDLE) || (r_state == S_ACCUM)) && w_start;
    assign w_step_end = (r_step == STEP_END);

    // One restoring-division step per cycle, MSB first; a zero count forces a zero quotient
    assign w_dividend = (r_state == S_DIV_Y) ? r_sum_y : r_sum_x;
    assign w_bitsel   = MSB_IDX - r_step;
    assign w_trial    = {r_rem, w_dividend[w_bitsel]};
    assign w_qbit     = (r_count != '0) && (w_trial >= {1'b0, r_count});
    assign w_rem_next = w_qbit ? CW'(w_trial - {1'b0, r_count}) : CW'(w_trial);

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_ACCUM;
            S_ACCUM: if (w_last) w_next = S_DIV_X;
            S_DIV_X: if (w_step_end) w_next = S_DIV_Y;
            S_DIV_Y: if (w_step_end) w_next = S_PUB;
            S_PUB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Accumulation and serial division datapath
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_step  <= '0;
            r_rem   <= '0;
            r_qx    <= '0;
            r_qy    <= '0;
        end else begin
            if (w_clear) begin
                r_count <= CW'(w_hit);
                r_sum_x <= w_hit ? SW'(r_h_d) : '0;
                r_sum_y <= w_hit ? SW'(r_v_d) : '0;
            end else if ((r_state == S_ACCUM) && w_hit) begin
                r_count <= r_count + CW'(1);
                r_sum_x <= r_sum_x + SW'(r_h_d);
                r_sum_y <= r_sum_y + SW'(r_v_d);
            end
            if ((r_state == S_DIV_X) || (r_state == S_DIV_Y)) begin
                r_step <= w_step_end ? '0 : r_step + DCW'(1);
                r_rem  <= w_step_end ? '0 : w_rem_next;
                if (r_state == S_DIV_X) r_qx <= {r_qx[XW-2:0], w_qbit};
                else                    r_qy <= {r_qy[YW-2:0], w_qbit};
            end else begin
                r_step <= '0;
                r_rem  <= '0;
            end
        end
    end

    // Published results; centroid holds when too few pixels were seen
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            ball_x     <= '0;
            ball_y     <= '0;
            ball_found <= 1'b0;
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (r_state == S_PUB);
            if (r_state == S_PUB) begin
                pix_count  <= r_count;
                ball_found <= (r_count >= CW'(MIN_PIX));
                if (r_count >= CW'(MIN_PIX)) begin
                    ball_x <= r_qx;
                    ball_y <= r_qy;
                end
            end
        end
    end

`ifdef BALL_BBOX_EN
    logic [XW-1:0] r_xmin, r_xmax;
    logic [YW-1:0] r_ymin, r_ymax;

    // Bounding box of mask pixels; min starts all-ones, max starts zero
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_xmin    <= '1;
            r_xmax    <= '0;
            r_ymin    <= '1;
            r_ymax    <= '0;
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
        end else begin
            if (w_clear) begin
                r_xmin <= w_hit ? XW'(r_h_d) : '1;
                r_xmax <= w_hit ? XW'(r_h_d) : '0;
                r_ymin <= w_hit ? YW'(r_v_d) : '1;
                r_ymax <= w_hit ? YW'(r_v_d) : '0;
            end else if ((r_state == S_ACCUM) && w_hit) begin
                if (XW'(r_h_d) < r_xmin) r_xmin <= XW'(r_h_d);
                if (XW'(r_h_d) > r_xmax) r_xmax <= XW'(r_h_d);
                if (YW'(r_v_d) < r_ymin) r_ymin <= YW'(r_v_d);
                if (YW'(r_v_d) > r_ymax) r_ymax <= YW'(r_v_d);
            end
            if ((r_state == S_PUB) && (r_count != '0)) begin
                bbox_xmin <= r_xmin;
                bbox_xmax <= r_xmax;
                bbox_ymin <= r_ymin;
                bbox_ymax <= r_ymax;
            end
        end
    end
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_ball_locator.sv
// Directed bench for ball_locator on a reduced 128x64 active area (130x66 total raster).
module tb_ball_locator;

    localparam int H_ACT = 128;
    localparam int V_ACT = 64;
    localparam int H_TOT = 130;
    localparam int V_TOT = 66;

    logic        PCLK = 1'b0;
    logic        RST_N;
    logic [11:0] VtcHCnt;
    logic [10:0] VtcVCnt;
    logic        mask_i;
    logic [8:0]  ball_x;
    logic [7:0]  ball_y;
    logic        ball_found;
    logic [16:0] pix_count;
    logic [8:0]  bbox_xmin, bbox_xmax;
    logic [7:0]  bbox_ymin, bbox_ymax;
    logic        frame_done;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;
    int done_cyc = -1;
    int mask_cyc = -1;
    int ph = H_TOT - 1;
    int pv = V_TOT - 1;

    ball_locator #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .MIN_PIX(16)) dut (
        .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .mask_i(mask_i), .ball_x(ball_x), .ball_y(ball_y), .ball_found(ball_found),
        .pix_count(pix_count), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .frame_done(frame_done)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (frame_done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 empty, 1 4x4 block, 2 single pixel, 3 all ones, 4 ones only outside active area
    function automatic logic pat(input int mode, input int h, input int v);
        logic act;
        act = (h < H_ACT) && (v < V_ACT);
        case (mode)
            1:       return (h >= 100) && (h <= 103) && (v >= 50) && (v <= 53);
            2:       return (h == 10) && (v == 10);
            3:       return 1'b1;
            4:       return !act;
            default: return 1'b0;
        endcase
    endfunction

    // Drives nlines raster lines; mask follows the counters by one cycle
    task automatic run_frame(input int mode, input int nlines, input int rst_line);
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                @(posedge PCLK);
                #1;
                if (v == rst_line && h == 5) begin
                    RST_N = 1'b0;
                    #1;
                    chk("rst_async_x", 32'(ball_x), 0);
                    chk("rst_async_y", 32'(ball_y), 0);
                    chk("rst_async_found", 32'(ball_found), 0);
                    chk("rst_async_count", 32'(pix_count), 0);
                end else if (v == rst_line && h == 10) begin
                    RST_N = 1'b1;
                end
                mask_i = pat(mode, ph, pv);
                if (ph == H_ACT - 1 && pv == V_ACT - 1) mask_cyc = cyc;
                VtcHCnt = 12'(h);
                VtcVCnt = 11'(v);
                ph = h;
                pv = v;
            end
        end
    endtask

    task automatic chk_frame(input string tag, input int base, input int cnt, input int found,
                             input int x, input int y, input logic lat_chk);
        chk({tag, "_pulses"}, 32'(n_done - base), 1);
        chk({tag, "_count"}, 32'(pix_count), 32'(cnt));
        chk({tag, "_found"}, 32'(ball_found), 32'(found));
        chk({tag, "_x"}, 32'(ball_x), 32'(x));
        chk({tag, "_y"}, 32'(ball_y), 32'(y));
        if (lat_chk) chk({tag, "_latency"}, 32'(done_cyc - mask_cyc), 50);
    endtask

    task automatic chk_bbox(input string tag, input int x0, input int x1, input int y0, input int y1);
`ifdef BALL_BBOX_EN
        chk({tag, "_bxmin"}, 32'(bbox_xmin), 32'(x0));
        chk({tag, "_bxmax"}, 32'(bbox_xmax), 32'(x1));
        chk({tag, "_bymin"}, 32'(bbox_ymin), 32'(y0));
        chk({tag, "_bymax"}, 32'(bbox_ymax), 32'(y1));
`else
        chk({tag, "_bxmin"}, 32'(bbox_xmin), 0);
        chk({tag, "_bxmax"}, 32'(bbox_xmax), 0);
        chk({tag, "_bymin"}, 32'(bbox_ymin), 0);
        chk({tag, "_bymax"}, 32'(bbox_ymax), 0);
        if (x0 + x1 + y0 + y1 < 0) $display("unreachable");
`endif
    endtask

    initial begin
        int base;
        RST_N   = 1'b0;
        VtcHCnt = 12'(H_TOT - 1);
        VtcVCnt = 11'(V_TOT - 1);
        mask_i  = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_x", 32'(ball_x), 0);
        chk("reset_found", 32'(ball_found), 0);
        chk("reset_count", 32'(pix_count), 0);
        chk("reset_done", 32'(frame_done), 0);
        RST_N = 1'b1;

        // 4x4 block: sums 1624/824 over 16 pixels
        base = n_done;
        run_frame(1, V_TOT, -1);
        chk_frame("block", base, 16, 1, 101, 51, 1'b1);
        chk_bbox("block", 100, 103, 50, 53);

        // Empty frame holds the centroid and bbox
        base = n_done;
        run_frame(0, V_TOT, -1);
        chk_frame("empty", base, 0, 0, 101, 51, 1'b1);
        chk_bbox("empty", 100, 103, 50, 53);

        // Truncated all-ones frame restarted by a single-pixel frame
        base = n_done;
        run_frame(3, 40, -1);
        run_frame(2, V_TOT, -1);
        chk_frame("single", base, 1, 0, 101, 51, 1'b1);
        chk_bbox("single", 10, 10, 10, 10);

        // All ones, blanking included: 8192 pixels, centroid floor(63.5), floor(31.5)
        base = n_done;
        run_frame(3, V_TOT, -1);
        chk_frame("full", base, 8192, 1, 63, 31, 1'b1);
        chk_bbox("full", 0, 127, 0, 63);

        // Reset mid-frame: no pulse for the aborted frame, next full frame publishes
        base = n_done;
        run_frame(1, V_TOT, 32);
        chk("abort_pulses", 32'(n_done - base), 0);
        chk("abort_count", 32'(pix_count), 0);
        base = n_done;
        run_frame(1, V_TOT, -1);
        chk_frame("after_rst", base, 16, 1, 101, 51, 1'b1);

        // Mask only in blanking never accumulates
        base = n_done;
        run_frame(4, V_TOT, -1);
        chk_frame("blank", base, 0, 0, 101, 51, 1'b1);
        chk_bbox("blank", 100, 103, 50, 53);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
